qoa_spi_frame_rx: RTL and testbench

QOA_SPI_FRAME_RX -- requirements
Module: qoa_spi_frame_rx

---
 rtl/qoa_spi_frame_rx.sv | 148 ++++++++++++++
 tb/tb_qoa_spi_frame_rx.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qoa_spi_frame_rx.sv
// -----------------------------------------------------------------------------
// qoa_spi_frame_rx
//   SPI-slave frame receiver, clocked only by the SPI clock. Bits are shifted
//   in MSB first while cs_n is low. The first byte of a frame is a command.
//   Several commands may be chained in one frame, because a WRITE returns to
//   command decoding once its payload is consumed. Payload bytes and events
//   leave the sclk domain as toggles, which a consumer in the system-clock
//   domain synchronises. data_byte is held for at least 8 sclk cycles, so it
//   is stable by the time the synchronised toggle is seen.
//
//   Command byte: opcode = byte[7:6], len = byte[LEN_W-1:0]
//     00 NOP        nothing happens
//     01 WRITE      the next len+1 bytes are payload
//     10 READ       rd_tgl flips; the rest of the frame is ignored
//     11 DEC_RESET  drst_tgl flips
//
// Ports
//   sclk       in   SPI clock, the only clock (rising edge)
//   rst_n      in   synchronous active-low reset; beats cs_n and byte completion
//   cs_n       in   chip select, active low; high clears the frame
//   mosi       in   serial data, MSB first
//   data_byte  out  last completed WRITE payload byte
//   data_tgl   out  flips once per payload byte
//   rd_tgl     out  flips once per READ command
//   drst_tgl   out  flips once per DEC_RESET command
//   frame_err  out  sticky malformed-frame flag; only reset clears it
//   err_count  out  malformed-frame count, saturates at 255
//   busy       out  inside a command, or partway through a byte
// -----------------------------------------------------------------------------
module qoa_spi_frame_rx #(
  parameter int LEN_W = 6
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       mosi,
  output logic [7:0] data_byte,
  output logic       data_tgl,
  output logic       rd_tgl,
  output logic       drst_tgl,
  output logic       frame_err,
  output logic [7:0] err_count,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_CMD,
    ST_PAYLOAD,
    ST_DISCARD
  } state_t;

  localparam logic [1:0]   OP_NOP       = 2'b00;
  localparam logic [1:0]   OP_WRITE     = 2'b01;
  localparam logic [1:0]   OP_READ      = 2'b10;
  localparam logic [1:0]   OP_DEC_RESET = 2'b11;
  localparam logic [LEN_W:0] REM_ONE    = (LEN_W+1)'(1);

  state_t           r_state;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_cnt;
  logic [LEN_W:0]   r_remaining;
  logic [7:0]       r_data_byte;
  logic             r_data_tgl;
  logic             r_rd_tgl;
  logic             r_drst_tgl;
  logic             r_frame_err;
  logic [7:0]       r_err_count;

  // The byte being completed on this edge includes the bit now on mosi.
  logic [7:0]       w_byte;
  logic             w_byte_done;
  logic [1:0]       w_opcode;
  logic [LEN_W-1:0] w_len;
  logic             w_malformed;

  assign w_byte      = {r_shift[6:0], mosi};
  assign w_byte_done = (r_bit_cnt == 3'd7);
  assign w_opcode    = w_byte[7:6];
  assign w_len       = w_byte[LEN_W-1:0];
  // When cs_n rises, a frame is bad if it ends inside a payload or partway
  // through a byte. The same edge clears both conditions, so extra idle edges
  // cannot count the frame again.
  assign w_malformed = (r_state == ST_PAYLOAD) || (r_bit_cnt != 3'd0);

  // NOTE: the reset is synchronous. It is tested inside the clocked block
  // because no edge other than sclk may start it. All state uses non-blocking
  // assignments, so each edge sees only the values from the previous edge.
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      r_state     <= ST_CMD;
      r_shift     <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_remaining <= '0;
      r_data_byte <= 8'h00;
      r_data_tgl  <= 1'b0;
      r_rd_tgl    <= 1'b0;
      r_drst_tgl  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_count <= 8'd0;
    end else if (cs_n) begin
      if (w_malformed) begin
        r_frame_err <= 1'b1;
        if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
      end
      r_state   <= ST_CMD;
      r_shift   <= 8'h00;
      r_bit_cnt <= 3'd0;
    end else begin
      r_shift   <= w_byte;
      r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_byte_done) begin
        unique case (r_state)
          ST_CMD: begin
            unique case (w_opcode)
              OP_NOP: ;
              OP_WRITE: begin
                r_remaining <= {1'b0, w_len} + REM_ONE;
                r_state     <= ST_PAYLOAD;
              end
              OP_READ: begin
                r_rd_tgl <= ~r_rd_tgl;
                r_state  <= ST_DISCARD;
              end
              OP_DEC_RESET: r_drst_tgl <= ~r_drst_tgl;
            endcase
          end
          ST_PAYLOAD: begin
            r_data_byte <= w_byte;
            r_data_tgl  <= ~r_data_tgl;
            r_remaining <= r_remaining - REM_ONE;
            if (r_remaining == REM_ONE) r_state <= ST_CMD;
          end
          ST_DISCARD: ;
          default: r_state <= ST_CMD;
        endcase
      end
    end
  end

  assign data_byte = r_data_byte;
  assign data_tgl  = r_data_tgl;
  assign rd_tgl    = r_rd_tgl;
  assign drst_tgl  = r_drst_tgl;
  assign frame_err = r_frame_err;
  assign err_count = r_err_count;
  assign busy      = (r_state != ST_CMD) || (r_bit_cnt != 3'd0);

endmodule

// File: tb/tb_qoa_spi_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_qoa_spi_frame_rx
//   Self-checking bench for qoa_spi_frame_rx. The reference model works at the
//   byte level. It tracks the payload bytes still owed, a discard flag and the
//   bit position inside the current byte, and it updates the expected outputs
//   once for each whole byte and once for each frame end.
// -----------------------------------------------------------------------------
module tb_qoa_spi_frame_rx;

  logic       sclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic [7:0] data_byte;
  logic       data_tgl;
  logic       rd_tgl;
  logic       drst_tgl;
  logic       frame_err;
  logic [7:0] err_count;
  logic       busy;

  qoa_spi_frame_rx #(.LEN_W(6)) dut (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .data_byte (data_byte),
    .data_tgl  (data_tgl),
    .rd_tgl    (rd_tgl),
    .drst_tgl  (drst_tgl),
    .frame_err (frame_err),
    .err_count (err_count),
    .busy      (busy)
  );

  always #5 sclk = ~sclk;

  int total = 0;
  int bad   = 0;

  // Count every change of data_tgl. Directed tests compare differences.
  int data_flips = 0;
  always @(data_tgl) data_flips++;

  // ---------------- reference model ----------------
  int         m_rem;      // payload bytes still owed by the current WRITE
  bit         m_discard;  // a READ has been seen in this frame
  int         m_bits;     // bits received in the current byte
  logic [7:0] m_data;
  bit         m_dt, m_rt, m_drt, m_err;
  int         m_cnt;

  function automatic void model_reset();
    m_rem = 0; m_discard = 0; m_bits = 0; m_data = 8'h00;
    m_dt = 0; m_rt = 0; m_drt = 0; m_err = 0; m_cnt = 0;
  endfunction

  function automatic void model_byte(logic [7:0] b);
    if (m_rem > 0) begin
      m_data = b;
      m_dt   = ~m_dt;
      m_rem  = m_rem - 1;
    end else if (!m_discard) begin
      case (b[7:6])
        2'b01: m_rem = int'(b[5:0]) + 1;
        2'b10: begin m_rt = ~m_rt; m_discard = 1; end
        2'b11: m_drt = ~m_drt;
        default: ;
      endcase
    end
  endfunction

  function automatic void model_frame_end();
    if (m_rem > 0 || m_bits != 0) begin
      m_err = 1;
      if (m_cnt < 255) m_cnt++;
    end
    m_rem = 0; m_discard = 0; m_bits = 0;
  endfunction

  function automatic logic [20:0] exp_vec();
    logic b;
    b = (m_rem > 0) || m_discard || (m_bits != 0);
    return {m_data, m_dt, m_rt, m_drt, m_err, m_cnt[7:0], b};
  endfunction

  function automatic logic [20:0] act_vec();
    return {data_byte, data_tgl, rd_tgl, drst_tgl, frame_err, err_count, busy};
  endfunction

  // ---------------- drivers ----------------
  // Change inputs on the falling edge and sample #1 after the rising edge.
  task automatic drive(input logic cs, input logic m);
    @(negedge sclk);
    cs_n = cs;
    mosi = m;
    @(posedge sclk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, b[7-i]);
      m_bits = (m_bits + 1) % 8;
    end
    if (n == 8) model_byte(b);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
  endtask

  task automatic idle(input int n);
    model_frame_end();
    for (int i = 0; i < n; i++) drive(1'b1, 1'($urandom_range(0, 1)));
  endtask

  task automatic apply_reset();
    @(negedge sclk);
    rst_n = 1'b0;
    cs_n  = 1'b1;
    repeat (2) @(posedge sclk);
    #1;
    model_reset();
    @(negedge sclk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    total++;
    if (act_vec() !== 21'h0) begin
      bad++;
      $display("FAIL reset_state: got %h want %h", act_vec(), 21'h0);
    end
  endtask

  task automatic test_write();
    int f0;
    f0 = data_flips;
    send_byte(8'h42);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL write_busy_mid: got %b want 1", busy);
    end
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    idle(1);
    total++;
    if (act_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL write_end: got %h want %h", act_vec(), exp_vec());
    end
    total++;
    if (data_flips - f0 != 3 || data_byte !== 8'h33 || frame_err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL write_flips: got flips=%0d byte=%h err=%b busy=%b want flips=3 byte=33 err=0 busy=0",
               data_flips - f0, data_byte, frame_err, busy);
    end
  endtask

  task automatic test_cmd_chain();
    int f0;
    logic rt0, dr0;
    f0 = data_flips; rt0 = rd_tgl; dr0 = drst_tgl;
    send_byte(8'hC0);
    total++;
    if (drst_tgl !== ~dr0) begin
      bad++;
      $display("FAIL chain_drst_edge: got %b want %b", drst_tgl, ~dr0);
    end
    send_byte(8'h80); send_byte(8'hAA);
    total++;
    if (act_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL chain_mid: got %h want %h", act_vec(), exp_vec());
    end
    idle(2);
    total++;
    if (rd_tgl !== ~rt0 || drst_tgl !== ~dr0 || data_flips != f0 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL chain_end: got rd=%b drst=%b flips=%0d err=%b want rd=%b drst=%b flips=0 err=0",
               rd_tgl, drst_tgl, data_flips - f0, frame_err, ~rt0, ~dr0);
    end
  endtask

  task automatic test_truncated_payload();
    apply_reset();
    send_byte(8'h41); send_byte(8'h55);
    idle(1);
    total++;
    if (data_byte !== 8'h55 || frame_err !== 1'b1 || err_count !== 8'd1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL trunc_err: got byte=%h err=%b cnt=%0d busy=%b want 55 1 1 0",
               data_byte, frame_err, err_count, busy);
    end
    send_byte(8'h40); send_byte(8'h9C);
    idle(1);
    total++;
    if (act_vec() !== exp_vec() || data_byte !== 8'h9C || err_count !== 8'd1) begin
      bad++;
      $display("FAIL trunc_recover: got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_partial_byte();
    int c0;
    c0 = err_count;
    send_bits(8'hB5, 5);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL partial_busy: got %b want 1", busy);
    end
    idle(3);
    total++;
    if (int'(err_count) != c0 + 1 || act_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL partial_drop: got cnt=%0d vec=%h want cnt=%0d vec=%h",
               err_count, act_vec(), c0 + 1, exp_vec());
    end
  endtask

  task automatic test_long_write();
    int f0;
    logic [7:0] b;
    f0 = data_flips;
    send_byte(8'h7F);
    for (int i = 0; i < 64; i++) begin
      b = 8'($urandom);
      send_byte(b);
    end
    send_byte(8'h00);
    total++;
    if (data_flips - f0 != 64 || busy !== 1'b0 || act_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL long_write: got flips=%0d vec=%h want flips=64 vec=%h",
               data_flips - f0, act_vec(), exp_vec());
    end
    idle(1);
    total++;
    if (act_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL long_write_end: got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int ncmd, op, len, npay, part;
    for (int fr = 0; fr < 40; fr++) begin
      ncmd = $urandom_range(1, 3);
      for (int c = 0; c < ncmd; c++) begin
        op  = $urandom_range(0, 3);
        len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 5);
        b   = {2'(op), 6'(len)};
        send_byte(b);
        npay = (op == 1) ? len + 1 : (op == 2 ? $urandom_range(0, 2) : 0);
        // Occasionally cut a WRITE short to produce a malformed frame.
        if (op == 1 && $urandom_range(0, 5) == 0) npay = $urandom_range(0, len);
        for (int p = 0; p < npay; p++) send_byte(8'($urandom));
      end
      part = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
      if (part != 0) send_bits(8'($urandom), part);
      total++;
      if (act_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL random_mid fr=%0d: got %h want %h", fr, act_vec(), exp_vec());
      end
      idle($urandom_range(1, 3));
      total++;
      if (act_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL random_end fr=%0d: got %h want %h", fr, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid_byte();
    int f0;
    send_byte(8'h41);
    send_bits(8'hA5, 7);
    f0 = data_flips;
    // The 8th bit arrives on the same edge as the reset.
    @(negedge sclk);
    cs_n  = 1'b0;
    mosi  = 1'b1;
    rst_n = 1'b0;
    @(posedge sclk);
    #1;
    model_reset();
    total++;
    if (act_vec() !== 21'h0 || (data_tgl === 1'b1)) begin
      bad++;
      $display("FAIL reset_mid_byte: got %h want %h (flips since=%0d)",
               act_vec(), 21'h0, data_flips - f0);
    end
    @(negedge sclk);
    rst_n = 1'b1;
    cs_n  = 1'b1;
    @(posedge sclk);
    #1;
    total++;
    if (act_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL reset_release: got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      send_bits(8'h80, 1);
      idle(1);
      total++;
      if (act_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL saturate i=%0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
    total++;
    if (err_count !== 8'd255 || frame_err !== 1'b1) begin
      bad++;
      $display("FAIL saturate_final: got cnt=%0d err=%b want 255 1", err_count, frame_err);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write();
    test_cmd_chain();
    test_truncated_payload();
    test_partial_byte();
    test_long_write();
    test_random();
    test_reset_mid_byte();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
